vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed 640x480 VGA controller.
//  Generates pixel coordinates, display-area flag, hSync/vSync/blank_n and frame/line strobes for any mode.
//  Timing, sync polarity and pixel-clock enable are all configurable.
//  Sits between the pixel clock domain and the game renderer / DAC pins.
// PARAMETERS
//  CNT_W    11   width of coordinate counters; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch, pixels
//  H_SYNC   96   horizontal sync width, pixels
//  H_BP     48   horizontal back porch, pixels
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vertical sync width, lines
//  V_BP     33   vertical back porch, lines
//  H_POL    0    hSync active level (0 = active-low)
//  V_POL    0    vSync active level (0 = active-low)
// PORTS
//  VGA_clk     in   1      pixel/system clock; sole clock
//  reset       in   1      synchronous, active-high reset
//  pix_en      in   1      pixel advance enable; tie 1 when VGA_clk is the pixel clock
//  xCount      out  CNT_W  horizontal coordinate, aligned with all other outputs
//  yCount      out  CNT_W  vertical coordinate, aligned
//  displayArea out  1      1 inside H_ACTIVE x V_ACTIVE
//  VGA_hSync   out  1      horizontal sync at H_POL level during sync interval
//  VGA_vSync   out  1      vertical sync at V_POL level during sync interval
//  blank_n     out  1      equals displayArea
//  line_start  out  1      1-clock pulse when xCount becomes 0
//  frame_start out  1      1-clock pulse when xCount==0 and yCount==0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; defaults 800 x 525.
//  - Stage 0: h_cnt counts 0..H_TOTAL-1 on pix_en and wraps to 0.
//    v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1 -> 0.
//  - Stage 1: registered outputs, loaded on pix_en from the stage-0 values. Latency is 1 enabled clock; all outputs mutually aligned.
//  - displayArea = (h<H_ACTIVE)&&(v<V_ACTIVE).
//  - hSync interval: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Same form for vSync using the V_* parameters.
//  - Outside its interval, each sync sits at the inverse of its POL.
//  - line_start <= pix_en && h_cnt==0. frame_start <= pix_en && h_cnt==0 && v_cnt==0.
//    Both strobes are low on any clock with pix_en=0, so each pulse is exactly 1 VGA_clk wide.
//  - pix_en=0: counters and coordinate/sync/display outputs hold their values.
//  - Reset (any cycle, incl. mid-frame) has priority over pix_en:
//    h_cnt=v_cnt=0, xCount=yCount=0, displayArea=blank_n=0, line_start=frame_start=0,
//    VGA_hSync=~H_POL, VGA_vSync=~V_POL.
//  - First enabled clock after reset: outputs show x=0,y=0, displayArea=1, line_start=frame_start=1.
//  - Counters use ==TOTAL-1 compares only; no X-sensitive (===) compares. Arithmetic is unsigned CNT_W.
//  - Elaboration check: $error if H_TOTAL or V_TOTAL exceeds 2**CNT_W, or if any porch/sync parameter is 0.
// STRUCTURE
//  - Package vga_timing_pkg: mode constants (640x480@60 default set, 800x600@60), polarity localparams.
//  - Sub-module vga_axis_counter (params TOTAL, ACTIVE, FP, SYNC, POL).
//    Instanced once per axis; provides cnt, wrap, active, sync_raw.
//  - Top holds the cascade (v enable = pix_en & h wrap) and the stage-1 output register.
// TESTING
//  1. reset 3 clks, pix_en=1, run 2 frames: frame_start period 420000 clks, line_start period 800.
//     hSync low exactly 96 clks starting at xCount=656; vSync low exactly 2 lines at yCount=490..491.
//  2. displayArea/blank_n high exactly 640x480 = 307200 clks per frame.
//     Falls on the clock xCount goes 639->640; yCount wraps 524->0.
//  3. pix_en toggling 1,0,1,0: outputs advance every 2nd clk, strobes 1 clk wide.
//     Frame period doubles to 840000 clks.
//  4. reset asserted at xCount=300,yCount=200 for 1 clk: next clock shows reset values.
//     Following enabled clock shows x=0,y=0, frame_start=1.
//  5. H_POL=1,V_POL=1, small mode (H 8/2/3/2, V 4/1/1/1): hSync high for xCount 10..12.
//     vSync high at yCount 5; H_TOTAL 15, V_TOTAL 7 wrap verified.
//  6. Scoreboard compares every output against a reference model for the random pix_en pattern over 3 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared definitions for the raster timing generator: sync
//               polarity constants, a video-mode record type, the standard
//               640x480@60 and 800x600@60 mode tables, and a helper that
//               sums the four segments of one axis into its total length.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Sync polarity levels (the level driven during the sync interval)
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // One complete video mode: per-axis segment lengths plus sync polarity
    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, 800 x 525 total
    localparam vga_mode_t MODE_640X480_60 = '{
        h_active : 640, h_fp : 16, h_sync : 96,  h_bp : 48,
        v_active : 480, v_fp : 10, v_sync : 2,   v_bp : 33,
        h_pol    : POL_ACTIVE_LOW,
        v_pol    : POL_ACTIVE_LOW
    };

    // 800x600 @ 60 Hz, 40 MHz pixel clock, 1056 x 628 total
    localparam vga_mode_t MODE_800X600_60 = '{
        h_active : 800, h_fp : 40, h_sync : 128, h_bp : 88,
        v_active : 600, v_fp : 1,  v_sync : 4,   v_bp : 23,
        h_pol    : POL_ACTIVE_HIGH,
        v_pol    : POL_ACTIVE_HIGH
    };

    // Total length of one axis (active + front porch + sync + back porch)
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis (horizontal or vertical). Counts 0..TOTAL-1
//               on en_i and wraps to 0, and decodes the active region and
//               the sync pin level for the current count.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i      in   1      clock
//   rst_i      in   1      synchronous active-high reset, clears the count
//   en_i       in   1      advance enable
//   cnt_o      out  CNT_W  current count
//   wrap_o     out  1      count is at TOTAL-1 (next enabled clock wraps)
//   active_o   out  1      count < ACTIVE
//   sync_raw_o out  1      unregistered sync pin level (POL inside interval)
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int          CNT_W  = 11,
    parameter int unsigned TOTAL  = 800,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter logic        POL    = POL_ACTIVE_LOW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             active_o,
    output logic             sync_raw_o
);

    localparam logic [CNT_W-1:0] c_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] c_ACTIVE     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] c_SYNC_START = CNT_W'(ACTIVE + FP);
    // Back porch is non-zero, so the sync end is always below TOTAL and fits
    localparam logic [CNT_W-1:0] c_SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_last;
    logic             w_in_sync;

    assign w_at_last = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = w_at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_in_sync  = (cnt_q >= c_SYNC_START) && (cnt_q < c_SYNC_END);

    assign cnt_o      = cnt_q;
    assign wrap_o     = w_at_last;
    assign active_o   = (cnt_q < c_ACTIVE);
    assign sync_raw_o = w_in_sync ? POL : ~POL;

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator. Two cascaded axis
//               counters (stage 0) feed one output register (stage 1), so
//               every output is registered and all outputs are mutually
//               aligned, one enabled clock behind the counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   VGA_clk     in   1      pixel/system clock
//   reset       in   1      synchronous active-high reset, beats pix_en
//   pix_en      in   1      pixel advance enable
//   xCount      out  CNT_W  horizontal coordinate
//   yCount      out  CNT_W  vertical coordinate
//   displayArea out  1      inside the H_ACTIVE x V_ACTIVE window
//   VGA_hSync   out  1      H_POL during the horizontal sync interval
//   VGA_vSync   out  1      V_POL during the vertical sync interval
//   blank_n     out  1      copy of displayArea
//   line_start  out  1      one-clock pulse when xCount becomes 0
//   frame_start out  1      one-clock pulse when xCount and yCount become 0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int          CNT_W    = 11,
    parameter int unsigned H_ACTIVE = MODE_640X480_60.h_active,
    parameter int unsigned H_FP     = MODE_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = MODE_640X480_60.h_sync,
    parameter int unsigned H_BP     = MODE_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = MODE_640X480_60.v_active,
    parameter int unsigned V_FP     = MODE_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = MODE_640X480_60.v_sync,
    parameter int unsigned V_BP     = MODE_640X480_60.v_bp,
    parameter logic        H_POL    = POL_ACTIVE_LOW,
    parameter logic        V_POL    = POL_ACTIVE_LOW
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] xCount,
    output logic [CNT_W-1:0] yCount,
    output logic             displayArea,
    output logic             VGA_hSync,
    output logic             VGA_vSync,
    output logic             blank_n,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0)) begin : g_chk_h_zero
        $error("vga_timing_gen: horizontal porch/sync parameters must be non-zero");
    end
    if ((V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_chk_v_zero
        $error("vga_timing_gen: vertical porch/sync parameters must be non-zero");
    end

    // ------------------------------------------------------------------
    // Stage 0: cascaded axis counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_en;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    // End-of-frame flag is not needed: frame_start decodes the counters directly
    logic             w_v_wrap_unused;

    // The vertical axis steps only on the enabled clock that wraps the line
    assign w_v_en = pix_en & w_h_wrap;

    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .TOTAL  (H_TOTAL),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .POL    (H_POL)
    ) u_h_axis (
        .clk_i      (VGA_clk),
        .rst_i      (reset),
        .en_i       (pix_en),
        .cnt_o      (w_h_cnt),
        .wrap_o     (w_h_wrap),
        .active_o   (w_h_active),
        .sync_raw_o (w_h_sync)
    );

    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .TOTAL  (V_TOTAL),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .POL    (V_POL)
    ) u_v_axis (
        .clk_i      (VGA_clk),
        .rst_i      (reset),
        .en_i       (w_v_en),
        .cnt_o      (w_v_cnt),
        .wrap_o     (w_v_wrap_unused),
        .active_o   (w_v_active),
        .sync_raw_o (w_v_sync)
    );

    // ------------------------------------------------------------------
    // Stage 1: aligned output register
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             disp_q, disp_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             w_h_zero;
    logic             w_v_zero;

    assign w_h_zero = (w_h_cnt == '0);
    assign w_v_zero = (w_v_cnt == '0);

    always_comb begin
        // Coordinates and levels hold on idle clocks; strobes drop so each
        // pulse is exactly one clock wide whatever the enable pattern.
        x_d    = x_q;
        y_d    = y_q;
        disp_d = disp_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (pix_en) begin
            x_d    = w_h_cnt;
            y_d    = w_v_cnt;
            disp_d = w_h_active & w_v_active;
            hs_d   = w_h_sync;
            vs_d   = w_v_sync;
            ls_d   = w_h_zero;
            fs_d   = w_h_zero & w_v_zero;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            disp_q <= 1'b0;
            hs_q   <= ~H_POL;
            vs_q   <= ~V_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            disp_q <= disp_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign xCount      = x_q;
    assign yCount      = y_q;
    assign displayArea = disp_q;
    assign blank_n     = disp_q;
    assign VGA_hSync   = hs_q;
    assign VGA_vSync   = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench. Two small-mode instances share clock,
//               reset and pix_en: A (H 8/2/3/2, V 4/1/1/1, active-high syncs,
//               4-bit counters) and B (H 16/4/6/5, V 10/2/3/4, active-low
//               syncs, 5-bit counters). A reference model derives every
//               output from the count of enabled pixels since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    // Mode tables, index 0 = DUT A, 1 = DUT B
    localparam int HA  [2] = '{8, 16};
    localparam int HFP [2] = '{2, 4};
    localparam int HSW [2] = '{3, 6};
    localparam int HBP [2] = '{2, 5};
    localparam int VA  [2] = '{4, 10};
    localparam int VFP [2] = '{1, 2};
    localparam int VSW [2] = '{1, 3};
    localparam int VBP [2] = '{1, 4};
    localparam int HPOL[2] = '{1, 0};
    localparam int VPOL[2] = '{1, 0};

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        ls;
        logic        fs;
    } obs_t;

    logic [3:0] a_x, a_y;
    logic       a_disp, a_hs, a_vs, a_bl, a_ls, a_fs;
    logic [4:0] b_x, b_y;
    logic       b_disp, b_hs, b_vs, b_bl, b_ls, b_fs;
    obs_t       obs_a, obs_b;

    vga_timing_gen #(
        .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_a (
        .VGA_clk(clk), .reset(reset), .pix_en(pix_en),
        .xCount(a_x), .yCount(a_y), .displayArea(a_disp),
        .VGA_hSync(a_hs), .VGA_vSync(a_vs), .blank_n(a_bl),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_b (
        .VGA_clk(clk), .reset(reset), .pix_en(pix_en),
        .xCount(b_x), .yCount(b_y), .displayArea(b_disp),
        .VGA_hSync(b_hs), .VGA_vSync(b_vs), .blank_n(b_bl),
        .line_start(b_ls), .frame_start(b_fs)
    );

    assign obs_a = {7'd0, a_x, 7'd0, a_y, a_disp, a_hs, a_vs, a_bl, a_ls, a_fs};
    assign obs_b = {6'd0, b_x, 6'd0, b_y, b_disp, b_hs, b_vs, b_bl, b_ls, b_fs};

    function automatic obs_t get_obs(input int m);
        return (m == 0) ? obs_a : obs_b;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int m, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, m, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int htot(input int m);
        return HA[m] + HFP[m] + HSW[m] + HBP[m];
    endfunction

    function automatic int vtot(input int m);
        return VA[m] + VFP[m] + VSW[m] + VBP[m];
    endfunction

    function automatic obs_t reset_obs(input int m);
        obs_t o;
        o      = '0;
        o.hs   = (HPOL[m] == 0);
        o.vs   = (VPOL[m] == 0);
        return o;
    endfunction

    // Outputs shown on the clock that presents the n-th enabled pixel
    function automatic obs_t model_pix(input int m, input int n);
        obs_t o;
        int   p, x, y;
        p      = n % (htot(m) * vtot(m));
        x      = p % htot(m);
        y      = p / htot(m);
        o.x    = 11'(x);
        o.y    = 11'(y);
        o.disp = (x < HA[m]) && (y < VA[m]);
        o.bl   = o.disp;
        o.hs   = ((x >= HA[m] + HFP[m]) && (x < HA[m] + HFP[m] + HSW[m])) ?
                 (HPOL[m] != 0) : (HPOL[m] == 0);
        o.vs   = ((y >= VA[m] + VFP[m]) && (y < VA[m] + VFP[m] + VSW[m])) ?
                 (VPOL[m] != 0) : (VPOL[m] == 0);
        o.ls   = (x == 0);
        o.fs   = (p == 0);
        return o;
    endfunction

    obs_t exp_o [2];
    int   n_en  [2];
    logic model_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    exp_o[m] = reset_obs(m);
                    n_en[m]  = 0;
                end else if (pix_en) begin
                    exp_o[m] = model_pix(m, n_en[m]);
                    n_en[m]  = n_en[m] + 1;
                end else begin
                    exp_o[m].ls = 1'b0;
                    exp_o[m].fs = 1'b0;
                end
            end
            if (reset) model_valid = 1'b1;
        end
    end

    // Cycle-by-cycle compare, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int m = 0; m < 2; m++) begin
                    chk("xCount",      m, int'(get_obs(m).x),    int'(exp_o[m].x));
                    chk("yCount",      m, int'(get_obs(m).y),    int'(exp_o[m].y));
                    chk("displayArea", m, int'(get_obs(m).disp), int'(exp_o[m].disp));
                    chk("blank_n",     m, int'(get_obs(m).bl),   int'(exp_o[m].bl));
                    chk("VGA_hSync",   m, int'(get_obs(m).hs),   int'(exp_o[m].hs));
                    chk("VGA_vSync",   m, int'(get_obs(m).vs),   int'(exp_o[m].vs));
                    chk("line_start",  m, int'(get_obs(m).ls),   int'(exp_o[m].ls));
                    chk("frame_start", m, int'(get_obs(m).fs),   int'(exp_o[m].fs));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Literal expectations for the reset state of both instances
    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"},    0, int'(a_x),    0);
        chk({tag, "_y"},    0, int'(a_y),    0);
        chk({tag, "_disp"}, 0, int'(a_disp), 0);
        chk({tag, "_hs"},   0, int'(a_hs),   0);
        chk({tag, "_vs"},   0, int'(a_vs),   0);
        chk({tag, "_fs"},   0, int'(a_fs),   0);
        chk({tag, "_x"},    1, int'(b_x),    0);
        chk({tag, "_disp"}, 1, int'(b_disp), 0);
        chk({tag, "_hs"},   1, int'(b_hs),   1);
        chk({tag, "_vs"},   1, int'(b_vs),   1);
        chk({tag, "_ls"},   1, int'(b_ls),   0);
    endtask

    // Literal expectations for the first enabled clock after reset
    task automatic chk_first_pixel(input string tag);
        chk({tag, "_x"},    0, int'(a_x),    0);
        chk({tag, "_y"},    0, int'(a_y),    0);
        chk({tag, "_disp"}, 0, int'(a_disp), 1);
        chk({tag, "_ls"},   0, int'(a_ls),   1);
        chk({tag, "_fs"},   0, int'(a_fs),   1);
        chk({tag, "_y"},    1, int'(b_y),    0);
        chk({tag, "_bl"},   1, int'(b_bl),   1);
        chk({tag, "_fs"},   1, int'(b_fs),   1);
    endtask

    // Interval/period measurements; cycle 0 is the first-pixel clock already
    // sampled, and pix_en is high on every stride-th clock from there on.
    task automatic run_measure(input int ncyc, input int stride);
        int   last_fs [2];
        int   last_ls [2];
        int   disp_cnt[2];
        int   hs_run  [2];
        int   vs_run  [2];
        obs_t prv     [2];
        obs_t cur;
        logic hs_act, vs_act, hs_was, vs_was;
        for (int m = 0; m < 2; m++) begin
            last_fs[m]  = 0;
            last_ls[m]  = 0;
            prv[m]      = get_obs(m);
            disp_cnt[m] = int'(prv[m].disp);
            hs_run[m]   = 0;
            vs_run[m]   = 0;
        end
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            pix_en = ((cyc % stride) == 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                cur = get_obs(m);
                if (cur.fs) begin
                    chk("frame_period", m, cyc - last_fs[m], htot(m) * vtot(m) * stride);
                    last_fs[m] = cyc;
                end
                if (cur.ls) begin
                    chk("line_period", m, cyc - last_ls[m], htot(m) * stride);
                    chk("strobe_width", m, int'(prv[m].ls), 0);
                    last_ls[m] = cyc;
                end
                if (cyc < htot(m) * vtot(m) * stride) begin
                    disp_cnt[m] += int'(cur.disp);
                end else if (cyc == htot(m) * vtot(m) * stride) begin
                    chk("disp_per_frame", m, disp_cnt[m], HA[m] * VA[m] * stride);
                end
                hs_act = (cur.hs == (HPOL[m] != 0));
                hs_was = (prv[m].hs == (HPOL[m] != 0));
                if (hs_act) begin
                    if (!hs_was) chk("hsync_start_x", m, int'(cur.x), HA[m] + HFP[m]);
                    hs_run[m]++;
                end else if (hs_was) begin
                    chk("hsync_width", m, hs_run[m], HSW[m] * stride);
                    hs_run[m] = 0;
                end
                vs_act = (cur.vs == (VPOL[m] != 0));
                vs_was = (prv[m].vs == (VPOL[m] != 0));
                if (vs_act) begin
                    if (!vs_was) chk("vsync_start_y", m, int'(cur.y), VA[m] + VFP[m]);
                    vs_run[m]++;
                end else if (vs_was) begin
                    chk("vsync_width", m, vs_run[m], VSW[m] * htot(m) * stride);
                    vs_run[m] = 0;
                end
                if (prv[m].disp && !cur.disp && (int'(cur.y) < VA[m])) begin
                    chk("disp_fall_x", m, int'(cur.x), HA[m]);
                end
                if (cur.y < prv[m].y) begin
                    chk("y_wrap_from", m, int'(prv[m].y), vtot(m) - 1);
                end
                prv[m] = cur;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic found;

        // Free-running: 3 reset clocks, then two full B frames at pix_en=1
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (3) tick();
        chk_reset_state("reset");
        reset = 1'b0;
        tick();
        chk_first_pixel("first");
        run_measure(2 * 589 + 2, 1);

        // Half-rate enable: everything stretches by two
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        pix_en = 1'b1;
        tick();
        chk_first_pixel("half_first");
        run_measure(2 * 1178 + 2, 2);

        // Reset for one clock in the middle of a frame
        pix_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (int'(b_x) == 10 && int'(b_y) == 7) found = 1'b1;
            else tick();
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL midframe_reach dut1: got no x=10,y=7 within 2000 clocks, expected it");
        end
        reset = 1'b1;
        tick();
        chk_reset_state("mid_reset");
        reset = 1'b0;
        tick();
        chk_first_pixel("mid_first");

        // Random enable with rare resets, about three B frames of pixels
        for (int i = 0; i < 3600; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset  = 1'b0;
        pix_en = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
